// File: rtl/iomem_fabric.sv
// Memory/IO fabric: general RAM, parallel-exported VRAM, keyboard FIFO and vsync capture.
// Define IOMEM_FRAME_CNT_EN to build the FRAME_CNT register; otherwise it reads as unmapped.
module iomem_fabric #(
   parameter int          RAM_WORDS = 256,
   parameter int          VRAM_ROWS = 10,
   parameter int          KBD_DEPTH = 8,
   parameter logic [31:0] VRAM_BASE = 32'h1000,
   parameter logic [31:0] IO_BASE   = 32'h2000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       read_enable,
   input  logic                       write_enable,
   input  logic [31:0]                address,
   input  logic [31:0]                data_input,
   output logic [31:0]                data_output,
   output logic                       rd_valid,
   input  logic [7:0]                 kbd_data,
   input  logic                       kbd_valid,
   input  logic                       vsync,
   output logic [VRAM_ROWS-1:0][31:0] vram_output
);
   localparam int          RA         = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int          VA         = (VRAM_ROWS > 1) ? $clog2(VRAM_ROWS) : 1;
   localparam int          KP         = $clog2(KBD_DEPTH);
   localparam logic [31:0] RAM_BYTES  = 32'(4 * RAM_WORDS);
   localparam logic [31:0] VRAM_BYTES = 32'(4 * VRAM_ROWS);
   localparam logic [KP:0] KBD_FULL   = (KP+1)'(KBD_DEPTH);
   localparam logic [1:0]  IO_KBD_DATA = 2'd0;
   localparam logic [1:0]  IO_KBD_STAT = 2'd1;
   localparam logic [1:0]  IO_VSYNC    = 2'd2;

   // ---------------- address decode (RAM > VRAM > IO priority) ----------------
   logic [31:0]   vram_off, io_off;
   logic          hit_ram, hit_vram, hit_io;
   logic [RA-1:0] ram_idx;
   logic [VA-1:0] vram_idx;
   logic [1:0]    io_sel;
   logic          rd_go, wr_go;

   assign vram_off = address - VRAM_BASE;
   assign io_off   = address - IO_BASE;
   assign hit_ram  = address < RAM_BYTES;
   assign hit_vram = ~hit_ram & (vram_off < VRAM_BYTES);
   assign hit_io   = ~hit_ram & ~hit_vram & (io_off < 32'd16);
   assign ram_idx  = address[RA+1:2];
   assign vram_idx = vram_off[VA+1:2];
   assign io_sel   = io_off[3:2];
   assign rd_go    = read_enable & ~rst;
   assign wr_go    = write_enable & ~rst;

   // ---------------- storage ----------------
   logic [31:0]                ram [RAM_WORDS];
   logic [VRAM_ROWS-1:0][31:0] vram_q;

   always_ff @(posedge clk) begin
      if (wr_go && hit_ram) ram[ram_idx] <= data_input;
   end

   always_ff @(posedge clk) begin
      if (rst)                  vram_q <= '0;
      else if (wr_go && hit_vram) vram_q[vram_idx] <= data_input;
   end

   assign vram_output = vram_q;

   // ---------------- keyboard FIFO ----------------
   logic [7:0]    kbd_mem [KBD_DEPTH];
   logic [KP-1:0] wr_ptr, rd_ptr;
   logic [KP:0]   kbd_count;
   logic          kbd_ovf, kbd_empty, kbd_full;
   logic          kbd_pop, kbd_push, ovf_set, ovf_clr;

   assign kbd_empty = (kbd_count == '0);
   assign kbd_full  = (kbd_count == KBD_FULL);
   assign kbd_pop   = rd_go & hit_io & (io_sel == IO_KBD_DATA) & ~kbd_empty;
   // a pop in the same cycle frees the slot a full-FIFO push needs
   assign kbd_push  = ~rst & kbd_valid & (~kbd_full | kbd_pop);
   assign ovf_set   = kbd_valid & kbd_full & ~kbd_pop;
   assign ovf_clr   = wr_go & hit_io & (io_sel == IO_KBD_STAT);

   always_ff @(posedge clk) begin
      if (kbd_push) kbd_mem[wr_ptr] <= kbd_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         kbd_count <= '0;
         kbd_ovf   <= 1'b0;
      end else begin
         if (kbd_push) wr_ptr <= wr_ptr + 1'b1;
         if (kbd_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (kbd_push && !kbd_pop)      kbd_count <= kbd_count + 1'b1;
         else if (kbd_pop && !kbd_push) kbd_count <= kbd_count - 1'b1;
         kbd_ovf <= (kbd_ovf & ~ovf_clr) | ovf_set;
      end
   end

   // ---------------- vsync capture ----------------
   logic vs_s1, vs_s2, vs_s3, vs_flag, vs_rise, vs_rd;

   assign vs_rise = vs_s2 & ~vs_s3;
   assign vs_rd   = rd_go & hit_io & (io_sel == IO_VSYNC);

   always_ff @(posedge clk) begin
      if (rst) begin
         vs_s1   <= 1'b0;
         vs_s2   <= 1'b0;
         vs_s3   <= 1'b0;
         vs_flag <= 1'b0;
      end else begin
         vs_s1   <= vsync;
         vs_s2   <= vs_s1;
         vs_s3   <= vs_s2;
         // an edge landing on the clearing read keeps the flag set
         vs_flag <= vs_rise | (vs_flag & ~vs_rd);
      end
   end

   logic [31:0] frame_rd;
`ifdef IOMEM_FRAME_CNT_EN
   logic [31:0] frame_cnt;

   always_ff @(posedge clk) begin
      if (rst)          frame_cnt <= '0;
      else if (vs_rise) frame_cnt <= frame_cnt + 32'd1;
   end

   assign frame_rd = frame_cnt;
`else
   assign frame_rd = '0;
`endif

   // ---------------- read path ----------------
   logic [31:0] rd_val;

   always_comb begin
      rd_val = '0;
      if (hit_ram) begin
         rd_val = ram[ram_idx];
      end else if (hit_vram) begin
         rd_val = vram_q[vram_idx];
      end else if (hit_io) begin
         case (io_sel)
            IO_KBD_DATA: rd_val = kbd_empty ? 32'h0 : {24'h0, kbd_mem[rd_ptr]};
            IO_KBD_STAT: rd_val = {16'(kbd_count), 14'h0, kbd_ovf, kbd_empty};
            IO_VSYNC:    rd_val = {31'h0, vs_flag | vs_rise};
            default:     rd_val = frame_rd;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_output <= '0;
         rd_valid    <= 1'b0;
      end else begin
         rd_valid <= read_enable;
         if (read_enable) data_output <= rd_val;
      end
   end

endmodule

// File: tb/tb_iomem_fabric.sv
// Bench for iomem_fabric: directed scenarios plus random traffic against a queue/array model.
module tb_iomem_fabric;
   localparam int          RAM_WORDS = 256;
   localparam int          VRAM_ROWS = 10;
   localparam int          KBD_DEPTH = 8;
   localparam logic [31:0] VRAM_BASE = 32'h1000;
   localparam logic [31:0] IO_BASE   = 32'h2000;

   logic                       clk, rst, read_enable, write_enable, kbd_valid, vsync, rd_valid;
   logic [31:0]                address, data_input, data_output;
   logic [7:0]                 kbd_data;
   logic [VRAM_ROWS-1:0][31:0] vram_output;

   iomem_fabric #(
      .RAM_WORDS(RAM_WORDS), .VRAM_ROWS(VRAM_ROWS), .KBD_DEPTH(KBD_DEPTH),
      .VRAM_BASE(VRAM_BASE), .IO_BASE(IO_BASE)
   ) dut (
      .clk(clk), .rst(rst), .read_enable(read_enable), .write_enable(write_enable),
      .address(address), .data_input(data_input), .data_output(data_output),
      .rd_valid(rd_valid), .kbd_data(kbd_data), .kbd_valid(kbd_valid),
      .vsync(vsync), .vram_output(vram_output)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] ram_m [int];
   logic [31:0] vram_m [VRAM_ROWS];
   logic [7:0]  fifo_m [$];
   bit          ovf_m, vsf_m;
   logic [31:0] fcnt_m;
   bit [2:0]    vh;          // vh[k] = vsync sampled k+1 edges ago
   bit          exp_v, exp_known;
   logic [31:0] exp_d;
   bit          vs_lvl;

   task automatic model(input bit r, input bit re, input bit we, input logic [31:0] a,
                        input logic [31:0] d, input bit kv, input logic [7:0] kd, input bit vs);
      bit          rise, pop;
      int          region, idx;
      logic [31:0] v;
      bit          known;
      if (r) begin
         exp_v = 0;
         foreach (vram_m[i]) vram_m[i] = '0;
         fifo_m.delete();
         ovf_m = 0; vsf_m = 0; fcnt_m = '0; vh = '0;
         return;
      end
      rise = vh[1] && !vh[2];
      region = 0; idx = 0;
      if (a < 32'(4 * RAM_WORDS)) begin
         region = 1; idx = int'(a >> 2);
      end else if (a >= VRAM_BASE && a < VRAM_BASE + 32'(4 * VRAM_ROWS)) begin
         region = 2; idx = int'((a - VRAM_BASE) >> 2);
      end else if (a >= IO_BASE && a < IO_BASE + 32'd16) begin
         region = 3; idx = int'((a - IO_BASE) >> 2);
      end
      v = '0; known = 1; pop = 0;
      case (region)
         1: if (ram_m.exists(idx)) v = ram_m[idx]; else known = 0;
         2: v = vram_m[idx];
         3: case (idx)
               0: if (fifo_m.size() > 0) begin v = {24'h0, fifo_m[0]}; pop = re; end
               1: v = {16'(fifo_m.size()), 14'h0, ovf_m, fifo_m.size() == 0};
               2: v = {31'h0, vsf_m | rise};
`ifdef IOMEM_FRAME_CNT_EN
               default: v = fcnt_m;
`else
               default: v = '0;
`endif
            endcase
         default: v = '0;
      endcase
      exp_v = re;
      if (re) begin exp_d = v; exp_known = known; end
      if (we) begin
         if (region == 1) ram_m[idx] = d;
         else if (region == 2) vram_m[idx] = d;
         else if (region == 3 && idx == 1) ovf_m = 0;
      end
      if (pop) void'(fifo_m.pop_front());
      if (kv) begin
         if (fifo_m.size() < KBD_DEPTH) fifo_m.push_back(kd);
         else ovf_m = 1;
      end
      if (rise) vsf_m = 1;
      else if (re && region == 3 && idx == 2) vsf_m = 0;
      if (rise) fcnt_m = fcnt_m + 32'd1;
      vh = {vh[1:0], vs};
   endtask

   task automatic cyc(input bit r, input bit re, input bit we, input logic [31:0] a,
                      input logic [31:0] d, input bit kv, input logic [7:0] kd);
      rst = r; read_enable = re; write_enable = we; address = a; data_input = d;
      kbd_valid = kv; kbd_data = kd; vsync = vs_lvl;
      @(posedge clk);
      model(r, re, we, a, d, kv, kd, vs_lvl);
      #1;
      chk("rd_valid", 32'(rd_valid), 32'(exp_v));
      if (exp_v && exp_known) chk($sformatf("rdata@%08h", a), data_output, exp_d);
      for (int i = 0; i < VRAM_ROWS; i++)
         chk($sformatf("vram[%0d]", i), vram_output[i], vram_m[i]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'h0, 32'h0, 0, 8'h0);
   endtask
   task automatic rd(input logic [31:0] a);
      cyc(0, 1, 0, a, 32'h0, 0, 8'h0);
   endtask
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      cyc(0, 0, 1, a, d, 0, 8'h0);
   endtask
   task automatic push(input logic [7:0] kd);
      cyc(0, 0, 0, 32'h0, 32'h0, 1, kd);
   endtask

   logic [31:0] unmapped [5];
   logic [31:0] fc_exp;

   initial begin
      unmapped[0] = 32'(4 * RAM_WORDS);
      unmapped[1] = VRAM_BASE - 32'd4;
      unmapped[2] = VRAM_BASE + 32'(4 * VRAM_ROWS);
      unmapped[3] = IO_BASE + 32'd16;
      unmapped[4] = 32'hFFFF_FFFC;
      vs_lvl = 0;
      fcnt_m = '0;
`ifdef IOMEM_FRAME_CNT_EN
      fc_exp = 32'd3;
`else
      fc_exp = 32'd0;
`endif

      // reset, with a read and write offered during it
      cyc(1, 1, 1, 32'h10, 32'hBAD0BAD0, 1, 8'h77);
      cyc(1, 0, 0, 32'h0, 32'h0, 0, 8'h0);
      rd(IO_BASE + 32'h4); chk("rst_kbd_status", data_output, 32'h0000_0001);
      rd(IO_BASE + 32'h8); chk("rst_vsync", data_output, 32'h0);
      rd(IO_BASE + 32'hC); chk("rst_frame_cnt", data_output, 32'h0);

      // RAM write/read, read-during-write
      wr(32'h10, 32'hDEADBEEF);
      rd(32'h10); chk("ram_rd", data_output, 32'hDEADBEEF);
      chk("ram_rd_valid", 32'(rd_valid), 32'h1);
      cyc(0, 1, 1, 32'h13, 32'h12345678, 0, 8'h0); chk("rdw_old", data_output, 32'hDEADBEEF);
      rd(32'h10); chk("rdw_new", data_output, 32'h12345678);

      // VRAM
      wr(VRAM_BASE + 32'h8, 32'h0000_FF00); chk("vram2", vram_output[2], 32'h0000_FF00);
      rd(VRAM_BASE + 32'h8); chk("vram2_rd", data_output, 32'h0000_FF00);

      // unmapped
      wr(32'h3000, 32'h5555_5555);
      rd(32'h3000); chk("unmapped_rd", data_output, 32'h0);
      rd(unmapped[2]); chk("vram_end_rd", data_output, 32'h0);

      // FIFO overflow and drain
      for (int i = 1; i <= 9; i++) push(8'(i));
      rd(IO_BASE + 32'h4); chk("ovf_status", data_output, 32'h0008_0002);
      for (int i = 1; i <= 8; i++) begin
         rd(IO_BASE); chk("kbd_pop", data_output, 32'(i));
      end
      rd(IO_BASE); chk("kbd_empty_rd", data_output, 32'h0);
      rd(IO_BASE + 32'h4); chk("empty_status", data_output, 32'h0000_0003);
      wr(IO_BASE + 32'h4, 32'h0);
      rd(IO_BASE + 32'h4); chk("ovf_cleared", data_output, 32'h0000_0001);

      // full FIFO with simultaneous push and pop
      for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
      cyc(0, 1, 0, IO_BASE, 32'h0, 1, 8'hAA); chk("full_pushpop", data_output, 32'h11);
      rd(IO_BASE + 32'h4); chk("full_pushpop_stat", data_output, 32'h0008_0000);
      for (int i = 0; i < 8; i++) rd(IO_BASE);
      chk("last_code", data_output, 32'hAA);

      // vsync pulses
      for (int p = 0; p < 3; p++) begin
         vs_lvl = 1; idle(3);
         vs_lvl = 0; idle(3);
      end
      idle(3);
      rd(IO_BASE + 32'h8); chk("vsync_set", data_output, 32'h1);
      rd(IO_BASE + 32'h8); chk("vsync_clr", data_output, 32'h0);
      rd(IO_BASE + 32'hC); chk("frame_cnt", data_output, fc_exp);
      wr(IO_BASE + 32'hC, 32'h55);
      rd(IO_BASE + 32'hC); chk("frame_cnt_wr", data_output, fc_exp);

      // read coinciding with the synchronised rising edge
      vs_lvl = 1; idle(2);
      rd(IO_BASE + 32'h8); chk("vs_coinc1", data_output, 32'h1);
      rd(IO_BASE + 32'h8); chk("vs_coinc2", data_output, 32'h1);
      rd(IO_BASE + 32'h8); chk("vs_coinc3", data_output, 32'h0);
      vs_lvl = 0; idle(3);

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         bit          r, re, we, kv;
         logic [31:0] a;
         int          cat;
         r   = ($urandom_range(0, 199) == 0);
         re  = 1'($urandom_range(0, 1));
         we  = ($urandom_range(0, 3) == 0);
         kv  = ($urandom_range(0, 2) == 0);
         cat = $urandom_range(0, 9);
         if (cat < 4)      a = 32'($urandom_range(0, 15)) * 4;
         else if (cat < 6) a = VRAM_BASE + 32'($urandom_range(0, VRAM_ROWS - 1)) * 4;
         else if (cat < 9) a = IO_BASE + 32'($urandom_range(0, 3)) * 4;
         else              a = unmapped[$urandom_range(0, 4)];
         a[1:0] = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 5) == 0) vs_lvl = ~vs_lvl;
         cyc(r, re, we, a, $urandom, kv, 8'($urandom));
      end

      // final reset clears VRAM rows
      vs_lvl = 0;
      for (int i = 0; i < VRAM_ROWS; i++) wr(VRAM_BASE + 32'(4 * i), 32'hA5A5_0000 + 32'(i));
      cyc(1, 0, 0, 32'h0, 32'h0, 0, 8'h0);
      chk("rst_vram0", vram_output[0], 32'h0);
      idle(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
